// File: rtl/execute_stage_if.sv
// Execute-stage bus: decode/execute operands and controls in, branch resolution and execute/memory register out.
// Latency: none (wires only); the stage itself registers the M-side outputs one edge after capture.
// Backpressure: stallE flows back to the hazard unit, which holds the decode/execute register while it is high.
//
// Signals:
//   RD1E, RD2E, SignImmE, PCPlus4E  operands, immediate and PC+4 from the decode/execute register
//   RtE, RdE                        destination register candidates
//   RegWriteE .. BranchE            decoded control bits, ALUControlE selects the ALU operation
//   ForwardAE/BE, ResultW           forwarding selects (00 reg, 10 ALUOutM, 01 ResultW) and write-back value
//   stallE                          multiplier is holding the execute stage
//   PCBranchE, PCSrcE               combinational branch target / taken
//   ALUOutM .. MemWriteM            execute/memory register contents
interface execute_stage_if;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] SignImmE;
  logic [31:0] PCPlus4E;
  logic [4:0]  RtE;
  logic [4:0]  RdE;
  logic        RegWriteE;
  logic        MemtoRegE;
  logic        MemWriteE;
  logic        ALUSrcE;
  logic        RegDstE;
  logic        BranchE;
  logic [2:0]  ALUControlE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [31:0] ResultW;

  logic        stallE;
  logic [31:0] PCBranchE;
  logic        PCSrcE;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [4:0]  WriteRegM;
  logic        RegWriteM;
  logic        MemtoRegM;
  logic        MemWriteM;

  // Pipeline / hazard side that feeds the stage.
  modport master (
    output RD1E, RD2E, SignImmE, PCPlus4E, RtE, RdE,
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, BranchE, ALUControlE,
    output ForwardAE, ForwardBE, ResultW,
    input  stallE, PCBranchE, PCSrcE,
    input  ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM
  );

  // The execute stage itself.
  modport slave (
    input  RD1E, RD2E, SignImmE, PCPlus4E, RtE, RdE,
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, BranchE, ALUControlE,
    input  ForwardAE, ForwardBE, ResultW,
    output stallE, PCBranchE, PCSrcE,
    output ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM
  );
endinterface

// File: rtl/execute_stage.sv
// Pipelined MIPS-style execute stage: forwarding muxes, ALU, branch resolution, execute/memory register.
// Latency: one edge to the M outputs; multiply (EXECUTE_MULT_EN) stalls 33 cycles, product on the 34th edge.
// Backpressure: stallE holds the upstream instruction; the M register loads bubbles while it is high.
//
// Ports: clk (sole clock), reset (async, active low), bus (execute_stage_if.slave, see interface file).
// Build option: define EXECUTE_MULT_EN to include the iterative shift-add multiplier and its FSM.
//   Without it, ALUControlE=011 simply produces 0 with no stall and no FSM state exists.
module execute_stage (
  input  logic            clk,
  input  logic            reset,
  execute_stage_if.slave  bus
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Execute/memory register.
  logic [31:0] r_alu_out_m;
  logic [31:0] r_write_data_m;
  logic [4:0]  r_write_reg_m;
  logic        r_reg_write_m;
  logic        r_memto_reg_m;
  logic        r_mem_write_m;

  logic [31:0] w_src_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_src_b;
  logic [31:0] w_alu_comb;
  logic [31:0] w_alu_result;
  logic [4:0]  w_write_reg;
  logic [31:0] w_pc_branch;
  logic        w_stall;

  // Forwarding: the 11 encoding is unused and falls back to the register value.
  always_comb begin
    w_src_a = bus.RD1E;
    case (bus.ForwardAE)
      2'b10:   w_src_a = r_alu_out_m;
      2'b01:   w_src_a = bus.ResultW;
      default: w_src_a = bus.RD1E;
    endcase
  end

  always_comb begin
    w_fwd_b = bus.RD2E;
    case (bus.ForwardBE)
      2'b10:   w_fwd_b = r_alu_out_m;
      2'b01:   w_fwd_b = bus.ResultW;
      default: w_fwd_b = bus.RD2E;
    endcase
  end

  assign w_src_b = bus.ALUSrcE ? bus.SignImmE : w_fwd_b;

  // Single-cycle ALU. Multiply is not computed here; in the multiplier build the
  // product comes from the accumulator, otherwise 011 (and 100/101) give 0.
  always_comb begin
    w_alu_comb = 32'd0;
    case (bus.ALUControlE)
      ALU_ADD: w_alu_comb = w_src_a + w_src_b;
      ALU_SUB: w_alu_comb = w_src_a - w_src_b;
      ALU_AND: w_alu_comb = w_src_a & w_src_b;
      ALU_OR:  w_alu_comb = w_src_a | w_src_b;
      ALU_SLT: w_alu_comb = {31'd0, ($signed(w_src_a) < $signed(w_src_b))};
      default: w_alu_comb = 32'd0;
    endcase
  end

`ifdef EXECUTE_MULT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_fsm_stall;
  logic        w_is_mul;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;   // shifts left one place per step
  logic [31:0] r_mplier;  // shifts right; bit 0 gates the add

  assign w_is_mul = (bus.ALUControlE == ALU_MUL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fsm_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_mul) begin
          w_state_nxt = S_MUL;
          w_fsm_stall = 1'b1;
        end
      end
      S_MUL: begin
        w_fsm_stall = 1'b1;
        if (r_cnt == 5'd31) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Always drop back to IDLE: upstream advances this cycle, so the same
        // instruction is never seen in IDLE again.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operands are captured only on entry, so forwarding changes while the
  // multiply runs cannot disturb the product. Arithmetic wraps at 32 bits,
  // which yields exactly the low half of the unsigned product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= 5'd0;
      r_acc    <= 32'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mul) begin
            r_mcand  <= w_src_a;
            r_mplier <= w_src_b;
            r_cnt    <= 5'd0;
            r_acc    <= 32'd0;
          end
        end
        S_MUL: begin
          r_acc    <= r_acc + (r_mplier[0] ? r_mcand : 32'd0);
          r_mcand  <= {r_mcand[30:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_cnt    <= r_cnt + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Gate with reset so stallE drops the moment reset asserts, even if a
  // multiply is still presented on the inputs.
  assign w_stall      = reset & w_fsm_stall;
  assign w_alu_result = (r_state == S_DONE) ? r_acc : w_alu_comb;
`else
  assign w_stall      = 1'b0;
  assign w_alu_result = w_alu_comb;
`endif

  assign w_write_reg = bus.RegDstE ? bus.RdE : bus.RtE;
  assign w_pc_branch = bus.PCPlus4E + {bus.SignImmE[29:0], 2'b00};

  // The target keeps following the (held) inputs during a stall; only the
  // taken flag is suppressed so a stalled instruction cannot redirect fetch.
  assign bus.PCBranchE = w_pc_branch;
  assign bus.PCSrcE    = ~w_stall & bus.BranchE & (w_alu_result == 32'd0);
  assign bus.stallE    = w_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alu_out_m    <= 32'd0;
      r_write_data_m <= 32'd0;
      r_write_reg_m  <= 5'd0;
      r_reg_write_m  <= 1'b0;
      r_memto_reg_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
    end else if (w_stall) begin
      // Bubble: nothing may write the register file or memory.
      r_alu_out_m    <= 32'd0;
      r_write_data_m <= 32'd0;
      r_write_reg_m  <= 5'd0;
      r_reg_write_m  <= 1'b0;
      r_memto_reg_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
    end else begin
      r_alu_out_m    <= w_alu_result;
      r_write_data_m <= w_fwd_b;
      r_write_reg_m  <= w_write_reg;
      r_reg_write_m  <= bus.RegWriteE;
      r_memto_reg_m  <= bus.MemtoRegE;
      r_mem_write_m  <= bus.MemWriteE;
    end
  end

  assign bus.ALUOutM    = r_alu_out_m;
  assign bus.WriteDataM = r_write_data_m;
  assign bus.WriteRegM  = r_write_reg_m;
  assign bus.RegWriteM  = r_reg_write_m;
  assign bus.MemtoRegM  = r_memto_reg_m;
  assign bus.MemWriteM  = r_mem_write_m;

endmodule
